// File: rtl/rf_arbiter.sv
// rf_arbiter: shares one 32x8 register file between port A (CPU datapath)
// and port B (debug/loader). Every reset starts with a sweep that writes zero
// to all DEPTH registers before either port can be granted. Arbitration is
// round-robin on ties; the owner keeps the file for as long as it holds REQ.
//
// Build option: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles
// whenever the other port is waiting. Without it, ownership is unbounded.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing sweep, RF_ADRX = cnt, RF_WR = 1, no grants, BUSY = 1
// IDLE  | no owner, RF outputs parked at 0, arbitrate pending requests
// OWN_A | port A owns the register file, A_* passed through to RF_*
// OWN_B | port B owns the register file, B_* passed through to RF_*

module rf_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WR,
    input  logic [ADDR_W-1:0] A_ADRX,
    input  logic [ADDR_W-1:0] A_ADRY,
    input  logic [DATA_W-1:0] A_DIN,
    output logic              A_GNT,
    output logic [DATA_W-1:0] A_DX,
    output logic [DATA_W-1:0] A_DY,
    input  logic              B_REQ,
    input  logic              B_WR,
    input  logic [ADDR_W-1:0] B_ADRX,
    input  logic [ADDR_W-1:0] B_ADRY,
    input  logic [DATA_W-1:0] B_DIN,
    output logic              B_GNT,
    output logic [DATA_W-1:0] B_DX,
    output logic [DATA_W-1:0] B_DY,
    output logic [DATA_W-1:0] RF_DIN,
    output logic [ADDR_W-1:0] RF_ADRX,
    output logic [ADDR_W-1:0] RF_ADRY,
    output logic              RF_WR,
    input  logic [DATA_W-1:0] RF_DX,
    input  logic [DATA_W-1:0] RF_DY,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        OWN_A = 2'd2,
        OWN_B = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // The sweep walks the address space exactly once, so a mismatched
    // DEPTH would leave registers uncleared or wrap the counter early.
    if (DEPTH != (1 << ADDR_W) || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rf_arbiter: DEPTH must be 2**ADDR_W and MAX_HOLD >= 1");
    end

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_b;     // 1: port B was granted most recently
    logic              preempt_a;
    logic              preempt_b;
    logic              rf_wr_c;

`ifdef ARB_TIMEOUT_EN
    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;

    // Ownership timer: reloaded while not owning, counts down while owning
    // and saturates at zero so a late request from the other port still
    // preempts immediately.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            hold_cnt <= HOLD_INIT;
        end else if (state == OWN_A || state == OWN_B) begin
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end else begin
            hold_cnt <= HOLD_INIT;
        end
    end

    assign hold_done = (hold_cnt == '0);
    assign preempt_a = hold_done & B_REQ;
    assign preempt_b = hold_done & A_REQ;
`else
    assign preempt_a = 1'b0;
    assign preempt_b = 1'b0;
`endif

    // Arbitration FSM with registered grants; last-granted port loses ties.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state  <= CLEAR;
            cnt    <= '0;
            last_b <= 1'b1;
            A_GNT  <= 1'b0;
            B_GNT  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) state <= IDLE;
                end
                IDLE: begin
                    if (A_REQ && (!B_REQ || last_b)) begin
                        state  <= OWN_A;
                        A_GNT  <= 1'b1;
                        last_b <= 1'b0;
                    end else if (B_REQ) begin
                        state  <= OWN_B;
                        B_GNT  <= 1'b1;
                        last_b <= 1'b1;
                    end
                end
                OWN_A: begin
                    if (!A_REQ || preempt_a) begin
                        state <= IDLE;
                        A_GNT <= 1'b0;
                    end
                end
                OWN_B: begin
                    if (!B_REQ || preempt_b) begin
                        state <= IDLE;
                        B_GNT <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    A_GNT <= 1'b0;
                    B_GNT <= 1'b0;
                end
            endcase
        end
    end

    // Register file port mux: only the sweep or the current owner reaches RF_*.
    always_comb begin
        rf_wr_c = 1'b0;
        RF_ADRX = '0;
        RF_ADRY = '0;
        RF_DIN  = '0;
        case (state)
            CLEAR: begin
                rf_wr_c = 1'b1;
                RF_ADRX = cnt;
            end
            OWN_A: begin
                rf_wr_c = A_WR;
                RF_ADRX = A_ADRX;
                RF_ADRY = A_ADRY;
                RF_DIN  = A_DIN;
            end
            OWN_B: begin
                rf_wr_c = B_WR;
                RF_ADRX = B_ADRX;
                RF_ADRY = B_ADRY;
                RF_DIN  = B_DIN;
            end
            default: ;
        endcase
    end

    // State is already CLEAR while reset is held, so the write strobe is
    // gated with reset to keep the file untouched until release.
    assign RF_WR = rf_wr_c & RST_N;

    assign A_DX = A_GNT ? RF_DX : '0;
    assign A_DY = A_GNT ? RF_DY : '0;
    assign B_DX = B_GNT ? RF_DX : '0;
    assign B_DY = B_GNT ? RF_DY : '0;

    assign BUSY = (state == CLEAR);

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: a behavioural 32x8 register file (asynchronous read,
// synchronous write) sits on the RF_* side. Table-driven access vectors for
// the A port plus hand-written sequences for sweep, handover, isolation,
// mid-grant reset, round-robin ties and ownership limit.

module tb_rf_arbiter;

    logic       clk;
    logic       RST_N;
    logic       A_REQ, A_WR, A_GNT;
    logic [4:0] A_ADRX, A_ADRY;
    logic [7:0] A_DIN, A_DX, A_DY;
    logic       B_REQ, B_WR, B_GNT;
    logic [4:0] B_ADRX, B_ADRY;
    logic [7:0] B_DIN, B_DX, B_DY;
    logic [7:0] RF_DIN, RF_DX, RF_DY;
    logic [4:0] RF_ADRX, RF_ADRY;
    logic       RF_WR, BUSY;

    logic       preload;
    logic [7:0] rf_mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       wr;
        logic [4:0] adrx;
        logic [4:0] adry;
        logic [7:0] din;
        logic [7:0] dx;
        logic [7:0] dy;
    } vec_t;

    vec_t vecs [8];

    rf_arbiter dut (
        .clk     (clk),
        .RST_N   (RST_N),
        .A_REQ   (A_REQ),
        .A_WR    (A_WR),
        .A_ADRX  (A_ADRX),
        .A_ADRY  (A_ADRY),
        .A_DIN   (A_DIN),
        .A_GNT   (A_GNT),
        .A_DX    (A_DX),
        .A_DY    (A_DY),
        .B_REQ   (B_REQ),
        .B_WR    (B_WR),
        .B_ADRX  (B_ADRX),
        .B_ADRY  (B_ADRY),
        .B_DIN   (B_DIN),
        .B_GNT   (B_GNT),
        .B_DX    (B_DX),
        .B_DY    (B_DY),
        .RF_DIN  (RF_DIN),
        .RF_ADRX (RF_ADRX),
        .RF_ADRY (RF_ADRY),
        .RF_WR   (RF_WR),
        .RF_DX   (RF_DX),
        .RF_DY   (RF_DY),
        .BUSY    (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; preload fills it with a non-zero pattern so the
    // sweep has something to clear.
    always_ff @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 8'hA5;
        end else if (RF_WR) begin
            rf_mem[RF_ADRX] <= RF_DIN;
        end
    end

    assign RF_DX = rf_mem[RF_ADRX];
    assign RF_DY = rf_mem[RF_ADRY];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right at the negedge where reset has just been released.
    task automatic sweep_check();
        for (int i = 0; i < 32; i++) begin
            #1;
            check($sformatf("sweep_busy[%0d]", i), 32'(BUSY), 32'd1);
            check($sformatf("sweep_wr[%0d]", i), 32'(RF_WR), 32'd1);
            check($sformatf("sweep_adrx[%0d]", i), 32'(RF_ADRX), 32'(i));
            check($sformatf("sweep_din[%0d]", i), 32'(RF_DIN), 32'd0);
            check($sformatf("sweep_agnt[%0d]", i), 32'(A_GNT), 32'd0);
            check($sformatf("sweep_bgnt[%0d]", i), 32'(B_GNT), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        //            wr    adrx   adry   din     dx     dy
        vecs[0] = '{1'b1, 5'd3,  5'd0,  8'h09, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 5'd3,  5'd3,  8'h00, 8'h09, 8'h09};
        vecs[2] = '{1'b1, 5'd7,  5'd3,  8'h5A, 8'h00, 8'h09};
        vecs[3] = '{1'b0, 5'd7,  5'd3,  8'h00, 8'h5A, 8'h09};
        vecs[4] = '{1'b1, 5'd7,  5'd7,  8'hFF, 8'h5A, 8'h5A};
        vecs[5] = '{1'b0, 5'd7,  5'd3,  8'h00, 8'hFF, 8'h09};
        vecs[6] = '{1'b0, 5'd31, 5'd5,  8'h00, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 5'd5,  5'd31, 8'h00, 8'h00, 8'h00};

        RST_N   = 1'b0;
        preload = 1'b1;
        A_REQ = 1'b0; A_WR = 1'b0; A_ADRX = '0; A_ADRY = '0; A_DIN = '0;
        B_REQ = 1'b0; B_WR = 1'b0; B_ADRX = '0; B_ADRY = '0; B_DIN = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(BUSY), 32'd1);
        check("rst_rf_wr", 32'(RF_WR), 32'd0);
        check("rst_agnt", 32'(A_GNT), 32'd0);
        check("rst_bgnt", 32'(B_GNT), 32'd0);
        preload = 1'b0;

        // Sweep with A requesting throughout
        @(negedge clk);
        A_REQ = 1'b1;
        RST_N = 1'b1;
        sweep_check();
        #1;
        check("post_sweep_busy", 32'(BUSY), 32'd0);
        check("post_sweep_wr", 32'(RF_WR), 32'd0);
        check("post_sweep_agnt", 32'(A_GNT), 32'd0);
        @(negedge clk);
        #1;
        check("first_agnt", 32'(A_GNT), 32'd1);
        check("first_bgnt", 32'(B_GNT), 32'd0);

        // Table-driven A port accesses
        for (int v = 0; v < 8; v++) begin
            A_WR   = vecs[v].wr;
            A_ADRX = vecs[v].adrx;
            A_ADRY = vecs[v].adry;
            A_DIN  = vecs[v].din;
            #1;
            check($sformatf("vec%0d_rf_wr", v), 32'(RF_WR), 32'(vecs[v].wr));
            check($sformatf("vec%0d_rf_adrx", v), 32'(RF_ADRX), 32'(vecs[v].adrx));
            check($sformatf("vec%0d_a_dx", v), 32'(A_DX), 32'(vecs[v].dx));
            check($sformatf("vec%0d_a_dy", v), 32'(A_DY), 32'(vecs[v].dy));
            check($sformatf("vec%0d_b_dx", v), 32'(B_DX), 32'd0);
            check($sformatf("vec%0d_b_dy", v), 32'(B_DY), 32'd0);
            @(negedge clk);
        end
        A_WR = 1'b0;

        // Handover A -> B with a dead cycle
        A_REQ = 1'b0;
        B_REQ = 1'b1;
        B_ADRX = 5'd3;
        B_ADRY = 5'd7;
        #1;
        check("handover_agnt_hold", 32'(A_GNT), 32'd1);
        @(negedge clk);
        #1;
        check("dead_agnt", 32'(A_GNT), 32'd0);
        check("dead_bgnt", 32'(B_GNT), 32'd0);
        check("dead_b_dx", 32'(B_DX), 32'd0);
        check("dead_rf_adrx", 32'(RF_ADRX), 32'd0);
        @(negedge clk);
        #1;
        check("b_gnt", 32'(B_GNT), 32'd1);
        check("b_dx_reg3", 32'(B_DX), 32'h09);
        check("b_dy_reg7", 32'(B_DY), 32'hFF);
        check("a_dx_gated", 32'(A_DX), 32'd0);
        B_ADRX = 5'd5;
        #1;
        check("b_dx_reg5", 32'(B_DX), 32'd0);

        // Isolation: A tries to write register 8 while B owns
        @(negedge clk);
        A_WR = 1'b1; A_DIN = 8'd33; A_ADRX = 5'd8;
        B_ADRX = 5'd8; B_ADRY = 5'd8;
        #1;
        check("iso_rf_wr", 32'(RF_WR), 32'd0);
        check("iso_rf_din", 32'(RF_DIN), 32'd0);
        @(negedge clk);
        #1;
        check("iso_reg8", 32'(B_DX), 32'd0);
        A_WR = 1'b0;

        // B write path
        @(negedge clk);
        B_WR = 1'b1; B_ADRX = 5'd10; B_DIN = 8'h77;
        @(negedge clk);
        B_WR = 1'b0; B_ADRY = 5'd10;
        #1;
        check("b_write_readback", 32'(B_DY), 32'h77);

        // Mid-grant reset while B owns and is driving a write
        @(negedge clk);
        B_WR = 1'b1; B_ADRX = 5'd12; B_DIN = 8'h44;
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_bgnt", 32'(B_GNT), 32'd0);
        check("midrst_rf_wr", 32'(RF_WR), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd1);
        B_WR = 1'b0;
        B_REQ = 1'b0;
        @(negedge clk);
        RST_N = 1'b1;
        sweep_check();
        #1;
        check("post_sweep2_busy", 32'(BUSY), 32'd0);

        // Tie after reset: A wins first
        A_REQ = 1'b1; B_REQ = 1'b1;
        A_ADRX = 5'd3; A_ADRY = 5'd10;
        @(negedge clk);
        #1;
        check("tie1_agnt", 32'(A_GNT), 32'd1);
        check("tie1_bgnt", 32'(B_GNT), 32'd0);
        check("cleared_reg3", 32'(A_DX), 32'd0);
        check("cleared_reg10", 32'(A_DY), 32'd0);
        A_REQ = 1'b0;
        @(negedge clk);
        #1;
        check("tie_dead_agnt", 32'(A_GNT), 32'd0);
        check("tie_dead_bgnt", 32'(B_GNT), 32'd0);
        @(negedge clk);
        #1;
        check("tie_b_after_a", 32'(B_GNT), 32'd1);
        B_REQ = 1'b0;
        @(negedge clk);
        #1;
        check("b_release", 32'(B_GNT), 32'd0);
        A_REQ = 1'b1; B_REQ = 1'b1;
        @(negedge clk);
        #1;
        check("tie2_agnt", 32'(A_GNT), 32'd1);
        check("tie2_bgnt", 32'(B_GNT), 32'd0);

        // A holds REQ with B waiting; the cycle just checked is grant cycle 1
`ifdef ARB_TIMEOUT_EN
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_agnt[%0d]", k), 32'(A_GNT), 32'd1);
        end
        @(negedge clk);
        #1;
        check("preempt_dead_agnt", 32'(A_GNT), 32'd0);
        check("preempt_dead_bgnt", 32'(B_GNT), 32'd0);
        @(negedge clk);
        #1;
        check("preempt_bgnt", 32'(B_GNT), 32'd1);
        check("preempt_agnt", 32'(A_GNT), 32'd0);
`else
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_agnt[%0d]", k), 32'(A_GNT), 32'd1);
            check($sformatf("hold_bgnt[%0d]", k), 32'(B_GNT), 32'd0);
        end
`endif

        A_REQ = 1'b0; B_REQ = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
